// File: rtl/cache_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// Shared types for the cache/memory arbiter.
//
//   rv32i_types          : core-wide constants (performance counter width)
//   arbiteraddressmux    : select encoding for the pmem address source
//   cache_mem_arbiter_pkg: arbiter FSM states, line geometry, line alignment
//
// No ports; packages only.
// ----------------------------------------------------------------------------
package rv32i_types;
    localparam int perf_counter_width = 32;
endpackage

package arbiteraddressmux;
    typedef enum logic {
        sel_icache = 1'b0,
        sel_dcache = 1'b1
    } arbiteraddressmux_sel_t;
endpackage

package cache_mem_arbiter_pkg;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    // Lines are 32 bytes, so the byte offset bits never reach memory.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~32'h0000_001F;
    endfunction
endpackage

// File: rtl/cache_mem_arbiter_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter: synchronous up-counter that sticks at all-ones.
//
// Ports:
//   clk   in  1      clock
//   clear in  1      synchronous clear (wins over inc)
//   inc   in  1      count one event this cycle
//   count out WIDTH  current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter: shares the single cacheline memory port between the
// I-cache (read only) and the D-cache (read / write-back).
//
// The D-cache normally wins; after MAX_D_STREAK consecutive D grants taken
// while the I-cache was waiting, the I-cache is forced through once.
// Each transfer is IDLE -> SERVE_x -> (pmem_resp) -> DONE -> IDLE.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_read, i_address                 I-cache line read request
//   i_rdata, i_resp                   I-cache response (one-cycle pulse)
//   d_read, d_write, d_address,
//   d_wdata                           D-cache line read / write-back request
//   d_rdata, d_resp                   D-cache response (one-cycle pulse)
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata          memory request (from latched state)
//   pmem_rdata, pmem_resp             memory response
//   i_grant_count, d_grant_count,
//   conflict_count                    saturating performance counters
// ----------------------------------------------------------------------------
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
    import arbiteraddressmux::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int CNT_W        = rv32i_types::perf_counter_width
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [255:0]      i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [255:0]      d_wdata,
    output logic [255:0]      d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [255:0]      pmem_wdata,
    input  logic [255:0]      pmem_rdata,
    input  logic              pmem_resp,

    output logic [CNT_W-1:0]  i_grant_count,
    output logic [CNT_W-1:0]  d_grant_count,
    output logic [CNT_W-1:0]  conflict_count
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t             state_q, state_d;
    logic [ADDR_W-1:0]      addr_q;
    logic [LINE_W-1:0]      wdata_q;
    logic                   write_q;
    logic [STREAK_W-1:0]    streak_q;

    logic                   d_req;
    logic                   grant_i, grant_d;
    logic                   i_forced;
    arbiteraddressmux_sel_t addr_sel;
    logic [ADDR_W-1:0]      mux_address;

    assign d_req    = d_read | d_write;
    assign i_forced = i_read && (streak_q == STREAK_MAX);

    always_comb begin
        state_d  = state_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        addr_sel = sel_icache;
        case (state_q)
            IDLE: begin
                if (d_req && !i_forced) begin
                    grant_d  = 1'b1;
                    addr_sel = sel_dcache;
                    state_d  = SERVE_D;
                end else if (i_read) begin
                    grant_i  = 1'b1;
                    state_d  = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mux_address = (addr_sel == sel_dcache) ? d_address : i_address;

    // A simultaneous read+write from the D-cache is treated as a write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_i || grant_d) begin
                addr_q  <= line_align(mux_address);
                write_q <= grant_d && d_write;
            end
            if (grant_d) begin
                wdata_q <= d_wdata;
            end
            if (grant_i) begin
                streak_q <= '0;
            end else if (grant_d) begin
                if (!i_read) begin
                    streak_q <= '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_q <= streak_q + {{(STREAK_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(d_read && d_write))
                else $error("cache_mem_arbiter: d_read and d_write asserted together");
        end
    end

    // Memory side is driven only from registered state, never from requesters.
    assign pmem_read    = (state_q == SERVE_I) || ((state_q == SERVE_D) && !write_q);
    assign pmem_write   = (state_q == SERVE_D) && write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = (state_q == SERVE_I) && pmem_resp;
    assign d_resp  = (state_q == SERVE_D) && pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;

    sat_counter #(.WIDTH(CNT_W)) u_i_grant_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (grant_i),
        .count (i_grant_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_d_grant_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (grant_d),
        .count (d_grant_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_conflict_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   ((state_q == IDLE) && i_read && d_req),
        .count (conflict_count)
    );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// Directed testbench for cache_mem_arbiter. Inputs change 1 time unit after
// each rising edge; outputs are compared a further time unit later.
// ----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  i_grant_count;
    logic [31:0]  d_grant_count;
    logic [31:0]  conflict_count;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_I1 = {8{32'h1234_5678}};
    localparam logic [255:0] PAT_D1 = {8{32'hCAFE_F00D}};

    // Expected grant order while I waits and D keeps requesting.
    bit exp_is_d [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    cache_mem_arbiter #(.MAX_D_STREAK(4), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_read         (i_read),
        .i_address      (i_address),
        .i_rdata        (i_rdata),
        .i_resp         (i_resp),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_address      (d_address),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_resp         (d_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .i_grant_count  (i_grant_count),
        .d_grant_count  (d_grant_count),
        .conflict_count (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [255:0] wd);
        i_read    = ir;
        i_address = ia;
        d_read    = dr;
        d_write   = dw;
        d_address = da;
        d_wdata   = wd;
    endtask

    task automatic mem(input logic resp, input logic [255:0] rdata);
        pmem_resp  = resp;
        pmem_rdata = rdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_pmem_read"},  pmem_read,  1'b0);
        checkOutput({tag, "_pmem_write"}, pmem_write, 1'b0);
        checkOutput({tag, "_i_resp"},     i_resp,     1'b0);
        checkOutput({tag, "_d_resp"},     d_resp,     1'b0);
        checkOutput({tag, "_i_rdata"},    i_rdata,    256'd0);
        checkOutput({tag, "_d_rdata"},    d_rdata,    256'd0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 256'd0);
        pmem_resp  = 1'b0;
        pmem_rdata = 256'd0;

        // ---------------- reset state ----------------
        next_cycle();
        next_cycle();
        check_idle_outputs("reset");
        checkOutput("reset_pmem_address", pmem_address, 32'h0);
        checkOutput("reset_pmem_wdata",   pmem_wdata,   256'd0);
        checkOutput("reset_i_cnt",        i_grant_count,  32'd0);
        checkOutput("reset_d_cnt",        d_grant_count,  32'd0);
        checkOutput("reset_conflict_cnt", conflict_count, 32'd0);
        rst = 1'b0;

        // ---------------- I read alone, 5-cycle memory ----------------
        $display("[TB] I-cache read alone");
        applyStimulus(1'b1, 32'h0000_1044, 1'b0, 1'b0, 32'h0, 256'd0);
        #1;
        checkOutput("t1_no_comb_strobe", pmem_read, 1'b0);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t1_wait%0d_pmem_read", k), pmem_read, 1'b1);
            checkOutput($sformatf("t1_wait%0d_addr", k), pmem_address, 32'h0000_1040);
            checkOutput($sformatf("t1_wait%0d_i_resp", k), i_resp, 1'b0);
            next_cycle();
        end
        checkOutput("t1_pmem_write", pmem_write, 1'b0);
        checkOutput("t1_i_cnt", i_grant_count, 32'd1);
        mem(1'b1, PAT_I1);
        checkOutput("t1_i_resp",  i_resp,  1'b1);
        checkOutput("t1_i_rdata", i_rdata, PAT_I1);
        checkOutput("t1_d_resp",  d_resp,  1'b0);
        checkOutput("t1_d_rdata", d_rdata, 256'd0);
        next_cycle();
        mem(1'b0, 256'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 256'd0);
        check_idle_outputs("t1_done");
        next_cycle();

        // ---------------- I and D write together ----------------
        $display("[TB] simultaneous I read and D write-back");
        applyStimulus(1'b1, 32'h0000_2000, 1'b0, 1'b1, 32'h8000_0020, PAT_A5);
        next_cycle();
        checkOutput("t2_pmem_write", pmem_write, 1'b1);
        checkOutput("t2_pmem_read",  pmem_read,  1'b0);
        checkOutput("t2_addr",       pmem_address, 32'h8000_0020);
        checkOutput("t2_wdata",      pmem_wdata, PAT_A5);
        checkOutput("t2_conflict",   conflict_count, 32'd1);
        checkOutput("t2_d_cnt",      d_grant_count, 32'd1);
        mem(1'b1, PAT_D1);
        checkOutput("t2_d_resp", d_resp, 1'b1);
        checkOutput("t2_i_resp", i_resp, 1'b0);
        checkOutput("t2_i_rdata", i_rdata, 256'd0);
        next_cycle();
        mem(1'b0, 256'd0);
        applyStimulus(1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0, 256'd0);
        check_idle_outputs("t2_done");
        next_cycle();
        next_cycle();
        checkOutput("t2_i_pmem_read", pmem_read, 1'b1);
        checkOutput("t2_i_addr",      pmem_address, 32'h0000_2000);
        checkOutput("t2_i_cnt",       i_grant_count, 32'd2);
        checkOutput("t2_conflict_hold", conflict_count, 32'd1);
        mem(1'b1, PAT_I1);
        checkOutput("t2_i_resp2", i_resp, 1'b1);
        next_cycle();
        mem(1'b0, 256'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 256'd0);
        next_cycle();

        // ---------------- anti-starvation streak ----------------
        $display("[TB] D streak with I waiting");
        applyStimulus(1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_4000, 256'd0);
        for (int g = 0; g < 7; g++) begin
            next_cycle();
            checkOutput($sformatf("t3_grant%0d_addr", g), pmem_address,
                        exp_is_d[g] ? 32'h0000_4000 : 32'h0000_3000);
            checkOutput($sformatf("t3_grant%0d_read", g), pmem_read, 1'b1);
            mem(1'b1, PAT_D1);
            checkOutput($sformatf("t3_grant%0d_d_resp", g), d_resp, exp_is_d[g]);
            checkOutput($sformatf("t3_grant%0d_i_resp", g), i_resp, !exp_is_d[g]);
            next_cycle();
            mem(1'b0, 256'd0);
            next_cycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 256'd0);
        checkOutput("t3_i_cnt",     i_grant_count,  32'd3);
        checkOutput("t3_d_cnt",     d_grant_count,  32'd7);
        checkOutput("t3_conflict",  conflict_count, 32'd8);

        // ---------------- address held while requester changes it ----------------
        $display("[TB] latched address during SERVE_D");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_5004, 256'd0);
        next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_6666, 256'd0);
        #1;
        checkOutput("t4_addr0", pmem_address, 32'h0000_5000);
        next_cycle();
        checkOutput("t4_addr1", pmem_address, 32'h0000_5000);
        mem(1'b1, PAT_D1);
        checkOutput("t4_addr_resp", pmem_address, 32'h0000_5000);
        checkOutput("t4_d_rdata",   d_rdata, PAT_D1);
        next_cycle();
        mem(1'b0, 256'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 256'd0);
        next_cycle();
        checkOutput("t4_d_cnt", d_grant_count, 32'd8);

        // ---------------- reset mid-transfer ----------------
        $display("[TB] reset during SERVE_D");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_7000, 256'd0);
        next_cycle();
        checkOutput("t5_pmem_read_before", pmem_read, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("t5_d_resp_before", d_resp, 1'b0);
        next_cycle();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 256'd0);
        mem(1'b1, PAT_D1);
        check_idle_outputs("t5_after");
        checkOutput("t5_i_cnt",     i_grant_count,  32'd0);
        checkOutput("t5_d_cnt",     d_grant_count,  32'd0);
        checkOutput("t5_conflict",  conflict_count, 32'd0);
        next_cycle();
        mem(1'b0, 256'd0);
        checkOutput("t5_still_idle", pmem_read, 1'b0);

        // ---------------- counter saturation ----------------
        $display("[TB] grant counter saturation");
        force dut.u_i_grant_cnt.count_q = 32'hFFFF_FFFF;
        next_cycle();
        release dut.u_i_grant_cnt.count_q;
        #1;
        checkOutput("t6_forced", i_grant_count, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 32'h0000_9000, 1'b0, 1'b0, 32'h0, 256'd0);
        next_cycle();
        checkOutput("t6_grant_read", pmem_read, 1'b1);
        checkOutput("t6_saturated",  i_grant_count, 32'hFFFF_FFFF);
        mem(1'b1, PAT_I1);
        next_cycle();
        mem(1'b0, 256'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 256'd0);
        next_cycle();
        checkOutput("t6_saturated_after", i_grant_count, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
